// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load handshake, status and round-key read port of the AES-128 key-schedule controller.
interface aes_key_sched_ctrl_if;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic         done;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_err;

  modport master (
    output key_valid, key_in, rd_en, rd_round,
    input  key_ready, busy, keys_valid, done, rd_key, rd_valid, rd_err
  );

  modport slave (
    input  key_valid, key_in, rd_en, rd_round,
    output key_ready, busy, keys_valid, done, rd_key, rd_valid, rd_err
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES-128 key expansion: one shared expansion step per cycle fills an
// 11-entry round-key file, which is then served through a registered read port.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[a];
endmodule

module aes_key_sched_ctrl (
  input logic                    clk,
  input logic                    rst,
  aes_key_sched_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [3:0]   rc;
  logic [127:0] rk [0:10];
  logic         key_ready;
  logic         load;
  logic         done_reg;
  logic [127:0] rd_key_reg;
  logic         rd_valid_reg;
  logic         rd_err_reg;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, rcon, t;
  logic [31:0]  n0, n1, n2, n3;

  always_comb begin
    state_next = state;
    key_ready  = (state != EXPAND) && !rst;
    load       = bus.key_valid && key_ready;
    case (state)
      IDLE, READY: if (load) state_next = EXPAND;
      EXPAND:      if (rc == 4'd9) state_next = READY;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rc       <= 4'd0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      done_reg <= (state == EXPAND) && (rc == 4'd9);
      if (load)
        rc <= 4'd0;
      else if (state == EXPAND)
        rc <= rc + 4'd1;
    end
  end

  // The single shared expansion step, always working on rk[rc].
  assign {w0, w1, w2, w3} = rk[rc];
  assign rot = {w3[23:0], w3[31:24]};

  sbox u_sbox0 (.a(rot[31:24]), .y(sub[31:24]));
  sbox u_sbox1 (.a(rot[23:16]), .y(sub[23:16]));
  sbox u_sbox2 (.a(rot[15:8]),  .y(sub[15:8]));
  sbox u_sbox3 (.a(rot[7:0]),   .y(sub[7:0]));

  always_comb begin
    rcon = 32'h0;
    case (rc)
      4'd0: rcon = 32'h01000000;
      4'd1: rcon = 32'h02000000;
      4'd2: rcon = 32'h04000000;
      4'd3: rcon = 32'h08000000;
      4'd4: rcon = 32'h10000000;
      4'd5: rcon = 32'h20000000;
      4'd6: rcon = 32'h40000000;
      4'd7: rcon = 32'h80000000;
      4'd8: rcon = 32'h1b000000;
      4'd9: rcon = 32'h36000000;
      default: rcon = 32'h0;
    endcase
  end

  assign t  = sub ^ rcon;
  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  // Round keys are qualified by keys_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load)
      rk[0] <= bus.key_in;
    else if (state == EXPAND)
      rk[rc + 4'd1] <= {n0, n1, n2, n3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_reg   <= 128'h0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
    end else if (bus.rd_en) begin
      if (state == READY && bus.rd_round <= 4'd10) begin
        rd_key_reg   <= rk[bus.rd_round];
        rd_valid_reg <= 1'b1;
        rd_err_reg   <= 1'b0;
      end else begin
        rd_key_reg   <= 128'h0;
        rd_valid_reg <= 1'b0;
        rd_err_reg   <= 1'b1;
      end
    end else begin
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
    end
  end

  assign bus.key_ready  = key_ready;
  assign bus.busy       = (state == EXPAND);
  assign bus.keys_valid = (state == READY);
  assign bus.done       = done_reg;
  assign bus.rd_key     = rd_key_reg;
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.rd_err     = rd_err_reg;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using the FIPS-197 A.1 and C.1 key schedules.
module tb_aes_key_sched_ctrl;
  logic clk;
  logic rst;
  int   pass_count;
  int   check_count;
  int   cyc;
  int   valid_run;
  logic seen_done;

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] c1_sched [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic kv, input logic [127:0] key,
                               input logic re, input logic [3:0] round);
    bus.key_valid = kv;
    bus.key_in    = key;
    bus.rd_en     = re;
    bus.rd_round  = round;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Waits for done with a bounded budget; cyc counts cycles since the load handshake.
  task automatic wait_done();
    while (bus.done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    tick();
    tick();

    checkOutput("rst_key_ready", {127'h0, bus.key_ready},  128'h0);
    checkOutput("rst_busy",      {127'h0, bus.busy},       128'h0);
    checkOutput("rst_keys_valid",{127'h0, bus.keys_valid}, 128'h0);
    checkOutput("rst_done",      {127'h0, bus.done},       128'h0);
    checkOutput("rst_rd_valid",  {127'h0, bus.rd_valid},   128'h0);
    checkOutput("rst_rd_err",    {127'h0, bus.rd_err},     128'h0);
    checkOutput("rst_rd_key",    bus.rd_key,               128'h0);
    rst = 1'b0;
    #1;
    checkOutput("idle_key_ready", {127'h0, bus.key_ready}, 128'h1);

    $display("[TB] load FIPS-197 A.1 key");
    applyStimulus(1'b1, KEY_A1, 1'b0, 4'd0);
    tick();
    cyc = 1;
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd0);
    checkOutput("exp_busy",       {127'h0, bus.busy},       128'h1);
    checkOutput("exp_key_ready",  {127'h0, bus.key_ready},  128'h0);
    checkOutput("exp_keys_valid", {127'h0, bus.keys_valid}, 128'h0);
    tick();
    cyc++;
    checkOutput("early_rd_err",   {127'h0, bus.rd_err},     128'h1);
    checkOutput("early_rd_valid", {127'h0, bus.rd_valid},   128'h0);
    applyStimulus(1'b1, KEY_C1, 1'b0, 4'd0);
    #1;
    checkOutput("exp_kv_ignored_ready", {127'h0, bus.key_ready}, 128'h0);
    tick();
    cyc++;
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    wait_done();
    checkOutput("a1_done_latency", 128'(cyc), 128'd11);
    checkOutput("a1_done",         {127'h0, bus.done},       128'h1);
    checkOutput("a1_keys_valid",   {127'h0, bus.keys_valid}, 128'h1);
    checkOutput("a1_key_ready",    {127'h0, bus.key_ready},  128'h1);
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd1);
    tick();
    checkOutput("a1_done_pulse_end", {127'h0, bus.done},     128'h0);
    checkOutput("a1_rk1",            bus.rd_key,             A1_RK1);
    checkOutput("a1_rk1_valid",      {127'h0, bus.rd_valid}, 128'h1);
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd2);
    tick();
    checkOutput("a1_rk2", bus.rd_key, A1_RK2);
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd11);
    tick();
    checkOutput("rd11_err",   {127'h0, bus.rd_err},   128'h1);
    checkOutput("rd11_key",   bus.rd_key,             128'h0);
    checkOutput("rd11_valid", {127'h0, bus.rd_valid}, 128'h0);
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd10);
    tick();
    checkOutput("a1_rk10", bus.rd_key, A1_RK10);
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd15);
    tick();
    checkOutput("rd15_err", {127'h0, bus.rd_err}, 128'h1);
    checkOutput("rd15_key", bus.rd_key,           128'h0);
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd10);
    tick();
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    tick();
    checkOutput("idle_rd_hold",  bus.rd_key,             A1_RK10);
    checkOutput("idle_rd_valid", {127'h0, bus.rd_valid}, 128'h0);
    checkOutput("idle_rd_err",   {127'h0, bus.rd_err},   128'h0);

    $display("[TB] reload with same-cycle read of round 0");
    applyStimulus(1'b1, KEY_C1, 1'b1, 4'd0);
    tick();
    cyc = 1;
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    checkOutput("reload_rd_old_key",   bus.rd_key,               KEY_A1);
    checkOutput("reload_rd_valid",     {127'h0, bus.rd_valid},   128'h1);
    checkOutput("reload_keys_dropped", {127'h0, bus.keys_valid}, 128'h0);
    checkOutput("reload_busy",         {127'h0, bus.busy},       128'h1);
    wait_done();
    checkOutput("c1_done_latency", 128'(cyc), 128'd11);

    valid_run = 0;
    for (int r = 0; r <= 10; r++) begin
      applyStimulus(1'b0, 128'h0, 1'b1, 4'(r));
      tick();
      checkOutput($sformatf("c1_rk%0d", r), bus.rd_key, c1_sched[r]);
      if (bus.rd_valid === 1'b1) valid_run++;
    end
    checkOutput("c1_valid_run", 128'(valid_run), 128'd11);
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    tick();

    $display("[TB] reset during expansion");
    applyStimulus(1'b1, KEY_A1, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_done |= bus.done;
    end
    rst = 1'b1;
    tick();
    checkOutput("midrst_busy",       {127'h0, bus.busy},       128'h0);
    checkOutput("midrst_keys_valid", {127'h0, bus.keys_valid}, 128'h0);
    checkOutput("midrst_rd_key",     bus.rd_key,               128'h0);
    checkOutput("midrst_key_ready",  {127'h0, bus.key_ready},  128'h0);
    rst = 1'b0;
    #1;
    checkOutput("postrst_key_ready", {127'h0, bus.key_ready}, 128'h1);
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd1);
    tick();
    seen_done |= bus.done;
    checkOutput("postrst_rd_err", {127'h0, bus.rd_err}, 128'h1);
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_done |= bus.done;
    end
    checkOutput("postrst_no_done",    {127'h0, seen_done},      128'h0);
    checkOutput("postrst_keys_valid", {127'h0, bus.keys_valid}, 128'h0);

    applyStimulus(1'b1, KEY_A1, 1'b0, 4'd0);
    tick();
    cyc = 1;
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    wait_done();
    checkOutput("relaunch_done_latency", 128'(cyc), 128'd11);
    applyStimulus(1'b0, 128'h0, 1'b1, 4'd10);
    tick();
    checkOutput("relaunch_rk10", bus.rd_key, A1_RK10);
    applyStimulus(1'b0, 128'h0, 1'b0, 4'd0);
    tick();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
